// File: rtl/cfa_stats_pkg.sv
// Shared types and constants for the CFA statistics engine.
package cfa_stats_pkg;

  localparam int SUM_BITS   = 32;
  // One load cycle followed by one restoring iteration per quotient bit.
  localparam int DIV_CYCLES = 33;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } stats_state_t;

  typedef enum logic [0:0] {
    DIV_IDLE = 1'b0,
    DIV_RUN  = 1'b1
  } div_state_t;

  // {row[0], col[0]} selects one of the four Bayer sites.
  typedef logic [1:0] chan_t;

  // Unsigned add that sticks at all-ones instead of wrapping.
  function automatic logic [SUM_BITS-1:0] sat_add(input logic [SUM_BITS-1:0] a,
                                                  input logic [SUM_BITS-1:0] b);
    logic [SUM_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SUM_BITS] ? '1 : s[SUM_BITS-1:0];
  endfunction

endpackage

// File: rtl/cfa_stats_divider.sv
// 32/32 unsigned restoring divider: one load edge, then one quotient bit per
// edge. A zero divisor yields a zero quotient.
module seq_divider
  import cfa_stats_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [SUM_BITS-1:0] dividend,
  input  logic [SUM_BITS-1:0] divisor,
  output logic                busy,
  output logic                done,
  output logic [SUM_BITS-1:0] quotient
);

  localparam logic [4:0] ITER_LAST = 5'(DIV_CYCLES - 2);

  logic [SUM_BITS-1:0] r_rem;
  logic [SUM_BITS-1:0] r_quo;
  logic [SUM_BITS-1:0] r_div;
  logic [4:0]          r_iter;
  logic                r_busy;
  logic                r_done;
  logic                r_dz;

  logic [SUM_BITS:0]   w_shift;
  logic                w_ge;
  logic [SUM_BITS-1:0] w_sub;

  // The remainder never reaches the divisor, so the low word of the
  // difference is exact whenever the subtraction is taken.
  assign w_shift = {r_rem, r_quo[SUM_BITS-1]};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  assign w_sub   = w_shift[SUM_BITS-1:0] - r_div;

  // Load operands on start, then shift/subtract until the last bit is resolved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_iter <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start && !r_busy) begin
        r_rem  <= '0;
        r_quo  <= dividend;
        r_div  <= divisor;
        r_dz   <= (divisor == '0);
        r_iter <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem  <= w_ge ? w_sub : w_shift[SUM_BITS-1:0];
        r_quo  <= {r_quo[SUM_BITS-2:0], w_ge};
        r_iter <= r_iter + 5'd1;
        if (r_iter == ITER_LAST) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign quotient = r_dz ? '0 : r_quo;

endmodule

// File: rtl/cfa_stats.sv
// Per-frame Bayer statistics: frame geometry, frame count and the integer
// average of each CFA channel, published once per frame.
module cfa_stats
  import cfa_stats_pkg::*;
#(
  parameter int MAX_COL_PIXELS = 1920,
  parameter int MAX_ROW_PIXELS = 1080,
  parameter int PIXEL_BITS     = 10,
  parameter int MAX_COL_WIDTH  = $clog2(MAX_COL_PIXELS),
  parameter int MAX_ROW_WIDTH  = $clog2(MAX_ROW_PIXELS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     pix_valid,
  input  logic [PIXEL_BITS-1:0]    pix_data,
  input  logic                     pix_sof,
  input  logic                     pix_eol,
  input  logic                     pix_eof,
  output logic [MAX_COL_WIDTH:0]   num_cols,
  output logic [MAX_ROW_WIDTH:0]   num_rows,
  output logic [31:0]              num_frames,
  output logic [31:0]              avg_chan_0,
  output logic [31:0]              avg_chan_1,
  output logic [31:0]              avg_chan_2,
  output logic [31:0]              avg_chan_3,
  output logic                     stats_valid,
  output logic                     stats_drop
);

  localparam int COLW = MAX_COL_WIDTH + 1;
  localparam int ROWW = MAX_ROW_WIDTH + 1;

  stats_state_t                   r_state;
  logic [COLW-1:0]                r_col;
  logic [ROWW-1:0]                r_row;
  logic [3:0][SUM_BITS-1:0]       r_sum, r_cnt;
  logic [3:0][SUM_BITS-1:0]       r_sum_p0, r_cnt_p0, r_sum_p1, r_cnt_p1;
  logic [COLW-1:0]                r_cols_p0, r_cols_p1, r_num_cols;
  logic [ROWW-1:0]                r_rows_p0, r_rows_p1, r_num_rows;
  logic                           r_eof_p0;
  div_state_t                     r_dstate;
  chan_t                          r_ch;
  logic                           r_kick;
  logic [2:0][SUM_BITS-1:0]       r_q;
  logic [31:0]                    r_frames;
  logic [3:0][SUM_BITS-1:0]       r_avg;
  logic                           r_valid, r_drop;

  logic                           w_acc;
  logic [COLW-1:0]                w_col_b;
  logic [ROWW-1:0]                w_row_b;
  chan_t                          w_ch, w_ld_ch;
  logic [3:0][SUM_BITS-1:0]       w_sum_n, w_cnt_n;
  logic                           w_start, w_busy, w_done;
  logic [SUM_BITS-1:0]            w_quo;

  // A sof pixel restarts the frame, so its position and the running totals
  // it builds on are taken as zero.
  assign w_acc   = pix_valid && en && (pix_sof || (r_state == ST_ACCUM));
  assign w_col_b = pix_sof ? '0 : r_col;
  assign w_row_b = pix_sof ? '0 : r_row;
  assign w_ch    = {w_row_b[0], w_col_b[0]};

  // Next-value sums and counts with the current pixel folded into its channel.
  always_comb begin
    w_sum_n       = pix_sof ? '0 : r_sum;
    w_cnt_n       = pix_sof ? '0 : r_cnt;
    w_sum_n[w_ch] = sat_add(w_sum_n[w_ch], SUM_BITS'(pix_data));
    w_cnt_n[w_ch] = sat_add(w_cnt_n[w_ch], SUM_BITS'(1));
  end

  // Accumulation FSM; on eof the finished totals move to stage p0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_col     <= '0;
      r_row     <= '0;
      r_sum     <= '0;
      r_cnt     <= '0;
      r_sum_p0  <= '0;
      r_cnt_p0  <= '0;
      r_cols_p0 <= '0;
      r_rows_p0 <= '0;
      r_eof_p0  <= 1'b0;
    end else begin
      r_eof_p0 <= 1'b0;
      if (w_acc) begin
        if (pix_eof) begin
          r_sum_p0  <= w_sum_n;
          r_cnt_p0  <= w_cnt_n;
          r_cols_p0 <= w_col_b + COLW'(1);
          r_rows_p0 <= w_row_b + ROWW'(1);
          r_eof_p0  <= 1'b1;
          r_sum     <= '0;
          r_cnt     <= '0;
          r_col     <= '0;
          r_row     <= '0;
          r_state   <= ST_IDLE;
        end else begin
          r_sum   <= w_sum_n;
          r_cnt   <= w_cnt_n;
          r_state <= ST_ACCUM;
          if (pix_eol) begin
            r_col <= '0;
            r_row <= w_row_b + ROWW'(1);
          end else begin
            r_col <= w_col_b + COLW'(1);
            r_row <= w_row_b;
          end
        end
      end else if ((r_state == ST_ACCUM) && !en) begin
        r_sum   <= '0;
        r_cnt   <= '0;
        r_col   <= '0;
        r_row   <= '0;
        r_state <= ST_IDLE;
      end
    end
  end

  // Channel 0 is loaded on the kick; each completion chains the next channel.
  assign w_ld_ch  = r_kick ? chan_t'(0) : chan_t'(r_ch + 2'd1);
  assign w_start  = !w_busy && (r_kick || (w_done && (r_ch != 2'd3)));

  seq_divider u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_start),
    .dividend (r_sum_p1[w_ld_ch]),
    .divisor  (r_cnt_p1[w_ld_ch]),
    .busy     (w_busy),
    .done     (w_done),
    .quotient (w_quo)
  );

  // Stage p1: frame count, snapshot/drop decision and result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_p1   <= '0;
      r_cnt_p1   <= '0;
      r_cols_p1  <= '0;
      r_rows_p1  <= '0;
      r_dstate   <= DIV_IDLE;
      r_ch       <= '0;
      r_kick     <= 1'b0;
      r_q        <= '0;
      r_frames   <= '0;
      r_avg      <= '0;
      r_num_cols <= '0;
      r_num_rows <= '0;
      r_valid    <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_kick  <= 1'b0;
      r_valid <= 1'b0;
      r_drop  <= 1'b0;
      if (r_eof_p0) begin
        r_frames <= r_frames + 32'd1;
        if (r_dstate == DIV_IDLE) begin
          r_sum_p1  <= r_sum_p0;
          r_cnt_p1  <= r_cnt_p0;
          r_cols_p1 <= r_cols_p0;
          r_rows_p1 <= r_rows_p0;
          r_dstate  <= DIV_RUN;
          r_ch      <= '0;
          r_kick    <= 1'b1;
        end else begin
          r_drop <= 1'b1;
        end
      end
      if (w_done) begin
        if (r_ch == 2'd3) begin
          r_avg      <= {w_quo, r_q[2], r_q[1], r_q[0]};
          r_num_cols <= r_cols_p1;
          r_num_rows <= r_rows_p1;
          r_valid    <= 1'b1;
          r_dstate   <= DIV_IDLE;
        end else begin
          r_q  <= {w_quo, r_q[2], r_q[1]};
          r_ch <= r_ch + 2'd1;
        end
      end
    end
  end

  assign num_cols    = r_num_cols;
  assign num_rows    = r_num_rows;
  assign num_frames  = r_frames;
  assign avg_chan_0  = r_avg[0];
  assign avg_chan_1  = r_avg[1];
  assign avg_chan_2  = r_avg[2];
  assign avg_chan_3  = r_avg[3];
  assign stats_valid = r_valid;
  assign stats_drop  = r_drop;

endmodule

// File: tb/tb_cfa_stats.sv
// Directed bench for cfa_stats: geometry, channel averages, publication
// latency, drop on back-to-back frames, restart, enable loss and reset.
module tb_cfa_stats;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        pix_valid = 1'b0;
  logic [9:0]  pix_data = '0;
  logic        pix_sof = 1'b0;
  logic        pix_eol = 1'b0;
  logic        pix_eof = 1'b0;
  logic [11:0] num_cols;
  logic [11:0] num_rows;
  logic [31:0] num_frames;
  logic [31:0] avg_chan_0, avg_chan_1, avg_chan_2, avg_chan_3;
  logic        stats_valid;
  logic        stats_drop;

  int errors = 0;
  int checks = 0;
  int vals[16];
  int n;

  cfa_stats dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_sof     (pix_sof),
    .pix_eol     (pix_eol),
    .pix_eof     (pix_eof),
    .num_cols    (num_cols),
    .num_rows    (num_rows),
    .num_frames  (num_frames),
    .avg_chan_0  (avg_chan_0),
    .avg_chan_1  (avg_chan_1),
    .avg_chan_2  (avg_chan_2),
    .avg_chan_3  (avg_chan_3),
    .stats_valid (stats_valid),
    .stats_drop  (stats_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One pixel sampled at the next rising edge; returns 1 ns after it.
  task automatic pix(input int v, input bit s, input bit l, input bit f);
    pix_valid = 1'b1;
    pix_data  = 10'(v);
    pix_sof   = s;
    pix_eol   = l;
    pix_eof   = f;
    @(posedge clk); #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_eol   = 1'b0;
    pix_eof   = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input int cols, input int rows);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        pix(vals[r*cols+c], (r == 0) && (c == 0), c == cols - 1,
            (c == cols - 1) && (r == rows - 1));
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < 16; i++) vals[i] = v;
  endtask

  // Edges until stats_valid is seen, bounded at 300.
  task automatic wait_stats(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!stats_valid && cnt < 300);
  endtask

  task automatic count_valid(input int cycles, output int pulses);
    pulses = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (stats_valid) pulses++;
    end
  endtask

  task automatic chk_avgs(input string tag, input int a0, input int a1, input int a2, input int a3);
    chk({tag, "_avg0"}, avg_chan_0, a0);
    chk({tag, "_avg1"}, avg_chan_1, a1);
    chk({tag, "_avg2"}, avg_chan_2, a2);
    chk({tag, "_avg3"}, avg_chan_3, a3);
  endtask

  initial begin
    // Reset state
    idle(3);
    chk("rst_cols", num_cols, 0);
    chk("rst_rows", num_rows, 0);
    chk("rst_frames", num_frames, 0);
    chk_avgs("rst", 0, 0, 0, 0);
    chk("rst_valid", stats_valid, 0);
    chk("rst_drop", stats_drop, 0);
    rst_n = 1'b1;
    idle(2);

    // 4x4 frame of 100s; publication exactly 134 edges after eof
    fill(100);
    send_frame(4, 4);
    chk("f1_frames_T", num_frames, 0);
    idle(1);
    chk("f1_frames_T1", num_frames, 1);
    wait_stats(n);
    chk("f1_latency", n, 133);
    chk("f1_cols", num_cols, 4);
    chk("f1_rows", num_rows, 4);
    chk_avgs("f1", 100, 100, 100, 100);
    idle(1);
    chk("f1_valid_pulse", stats_valid, 0);

    // 4x2 frame with distinct per-channel values
    vals[0] = 10; vals[1] = 20; vals[2] = 10; vals[3] = 20;
    vals[4] = 30; vals[5] = 40; vals[6] = 30; vals[7] = 40;
    send_frame(4, 2);
    wait_stats(n);
    chk("f2_latency", n, 134);
    chk("f2_cols", num_cols, 4);
    chk("f2_rows", num_rows, 2);
    chk("f2_frames", num_frames, 2);
    chk_avgs("f2", 10, 20, 30, 40);

    // 1x3 frame: odd-column channels have zero count
    vals[0] = 5; vals[1] = 7; vals[2] = 9;
    send_frame(1, 3);
    wait_stats(n);
    chk("f3_latency", n, 134);
    chk("f3_cols", num_cols, 1);
    chk("f3_rows", num_rows, 3);
    chk("f3_frames", num_frames, 3);
    chk_avgs("f3", 7, 0, 7, 0);

    // Two 2x2 frames with eofs 50 edges apart: second is dropped
    vals[0] = 1; vals[1] = 2; vals[2] = 3; vals[3] = 4;
    send_frame(2, 2);
    idle(46);
    fill(9);
    send_frame(2, 2);
    chk("f5_drop_T", stats_drop, 0);
    idle(1);
    chk("f5_drop_T1", stats_drop, 1);
    chk("f5_frames", num_frames, 5);
    wait_stats(n);
    chk("f5_latency", n, 83);
    chk("f5_cols", num_cols, 2);
    chk("f5_rows", num_rows, 2);
    chk_avgs("f5", 1, 2, 3, 4);
    count_valid(200, n);
    chk("f5_no_extra_valid", n, 0);

    // Partial frame restarted by a new sof
    pix(50, 1'b1, 1'b0, 1'b0);
    pix(50, 1'b0, 1'b0, 1'b0);
    pix(50, 1'b0, 1'b0, 1'b0);
    fill(8);
    send_frame(4, 4);
    wait_stats(n);
    chk("f6_latency", n, 134);
    chk("f6_frames", num_frames, 6);
    chk("f6_cols", num_cols, 4);
    chk("f6_rows", num_rows, 4);
    chk_avgs("f6", 8, 8, 8, 8);

    // Enable dropped mid-frame; the rest of the frame arrives without sof
    for (int i = 0; i < 5; i++) pix(77, i == 0, i == 3, 1'b0);
    en = 1'b0;
    idle(1);
    en = 1'b1;
    for (int i = 5; i < 16; i++) pix(77, 1'b0, (i % 4) == 3, i == 15);
    count_valid(200, n);
    chk("en_no_valid", n, 0);
    chk("en_frames", num_frames, 6);
    chk("en_avg0_hold", avg_chan_0, 8);

    // Reset asserted while the divider is running
    fill(3);
    send_frame(2, 2);
    idle(50);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_frames", num_frames, 0);
    chk("rstmid_cols", num_cols, 0);
    chk("rstmid_avg0", avg_chan_0, 0);
    idle(2);
    rst_n = 1'b1;
    count_valid(200, n);
    chk("rstmid_no_valid", n, 0);
    chk("rstmid_frames_after", num_frames, 0);
    chk_avgs("rstmid_after", 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cfa_stats.md
# cfa_stats

Per-frame Bayer statistics engine feeding the CSR block's read-only image registers. Watches the receive pixel stream and measures frame geometry (columns, rows). Counts completed frames. Accumulates each of the four CFA channels and publishes their integer averages once per frame, computed with a shared sequential divider.

## Interface
- MAX_COL_PIXELS, 1920: maximum pixels per line
- MAX_ROW_PIXELS, 1080: maximum lines per frame
- PIXEL_BITS, 10: pixel width
- MAX_COL_WIDTH, $clog2(MAX_COL_PIXELS): column counter width minus one
- MAX_ROW_WIDTH, $clog2(MAX_ROW_PIXELS): row counter width minus one

Ports:
- clk  in  1  single clock; all logic in this domain
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  statistics enable (driven by rx_en)
- pix_valid  in  1  pixel qualifier
- pix_data  in  PIXEL_BITS  pixel value
- pix_sof  in  1  first pixel of frame (qualified by pix_valid)
- pix_eol  in  1  last pixel of line (qualified by pix_valid)
- pix_eof  in  1  last pixel of frame; always coincides with pix_eol
- num_cols  out  MAX_COL_WIDTH+1  pixels in last line of last published frame
- num_rows  out  MAX_ROW_WIDTH+1  lines in last published frame
- num_frames  out  32  completed-frame counter
- avg_chan_0..avg_chan_3  out  32 each  floor(sum/count) per channel
- stats_valid  out  1  one-cycle pulse when num_cols/num_rows/avg_* update
- stats_drop  out  1  one-cycle pulse when a frame's stats are discarded (divider busy)

## Operation
- Reset: all outputs 0; state IDLE.
- Channel = {row[0], col[0]}: 0 = even row/even col, 1 = even/odd, 2 = odd/even, 3 = odd/odd. col/row are frame-relative and zero-based.
- States:
  - IDLE: ignores all pixels. Accepted sof with en=1 → ACCUM, counting that pixel.
  - ACCUM: each accepted pixel adds to sum[ch] and increments cnt[ch]; col increments.
    - eol: col→0, row+1.
    - eof: snapshot sums, counts, col+1 and row+1 into divider inputs; clear accumulators; → IDLE.
  - The divider is independent: DIV_IDLE / DIV_RUN(k=0..3).
- Sums and counts are 32-bit and saturate at 2^32−1; unreachable at default parameters (max 29 bits).
- num_frames increments on every accepted eof, wraps at 2^32, and increments even when stats are dropped.
- Divide by zero (cnt=0, e.g. 1-column frame for chan 1/3): that avg = 0.
- Boundary behaviour:
  - sof while in ACCUM: discard partial frame, restart accumulation at that pixel; num_frames unchanged.
  - eof accepted while the divider is in DIV_RUN: snapshot not taken; stats_drop pulses; running division completes normally.
  - en deasserted in ACCUM: discard partial frame → IDLE. Outputs hold; a divide in progress still completes.
  - pix_eol/pix_eof without pix_valid: ignored.
  - Pixels in IDLE without sof: ignored.
  - Reset mid-divide: everything returns to reset values; no stats_valid.

## Timing
- eof pixel accepted at edge T:
  - num_frames updates at T+1.
  - Snapshot registered at T+1.
- Channel k divides during cycles T+2+33k … T+34+33k: 1 load cycle + 32 restoring iterations.
- avg_chan_0..3, num_cols and num_rows all update at T+134, with stats_valid high for that cycle only.
- Minimum frame period for no drop: 134 cycles from eof to next eof.
- Accumulation has no backpressure; one pixel per cycle is sustained.

## Structure
- Package cfa_stats_pkg holds:
  - state typedefs (stats_state_t, div_state_t)
  - channel index typedef
  - DIV_CYCLES = 33
  - SUM_BITS = 32
- Sub-module seq_divider: 32/32 unsigned restoring divider.
  - Ports: start, dividend, divisor, busy, done, quotient.
  - divisor 0 → quotient 0.
  - Instantiated once and time-shared across the four channels.

## Test plan
- 4×4 frame, all pixels 100 → 134 cycles after eof: stats_valid; num_cols=4, num_rows=4, num_frames=1, all avg=100.
- 4×2 frame, row0 = 10,20,10,20 and row1 = 30,40,30,40 → avg_chan_0..3 = 10,20,30,40.
- 1×3 frame (pixels 5,7,9) → avg_chan_0=7, avg_chan_2=7, avg_chan_1=0, avg_chan_3=0; num_cols=1, num_rows=3.
- Two 2×2 frames with eofs 50 cycles apart → second eof:
  - stats_drop pulses; num_frames=2.
  - Outputs show frame 1 only.
- sof at pixel 3 of a 4×4 frame, then a full 4×4 frame of 8 → avg=8, num_frames=1.
- en dropped mid-frame → no stats_valid and num_frames unchanged.
- rst_n asserted mid-divide → all outputs 0 and no stats_valid afterwards.
